// File: rtl/drac_pkg.sv
// Shared types for the exe->writeback scalar path.
// Latency: n/a (types and defaults only).
// Backpressure: n/a.
package drac_pkg;

  // Default sizing of the writeback arbiter.
  localparam int unsigned WB_SLOW_FIFO_DEPTH = 4;
  localparam int unsigned WB_STARVE_LIMIT    = 8;

  // One scalar result travelling from execute to writeback.
  typedef struct packed {
    logic        valid;     // qualifies every other field
    logic [39:0] pc;
    logic [4:0]  rd;        // architectural destination
    logic [5:0]  prd;       // physical destination
    logic        regwr;     // result is written to the register file
    logic [63:0] result;
    logic [4:0]  gl_index;  // graduation-list slot, lets rename/ROB absorb reordering
    logic        ex_valid;  // result carries an exception
    logic [3:0]  ex_cause;
  } exe_wb_scalar_instr_t;

  localparam exe_wb_scalar_instr_t EXE_WB_SCALAR_NOP = '0;

  // Source chosen for the writeback register on a given cycle.
  typedef enum logic [1:0] {
    WB_SEL_NONE   = 2'd0,
    WB_SEL_ALU    = 2'd1,
    WB_SEL_FIFO   = 2'd2,
    WB_SEL_BYPASS = 2'd3
  } wb_sel_e;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order FIFO of scalar results; pointers/count async reset, storage unreset.
// Latency: push visible at head the cycle after it is written; head is combinational.
// Backpressure: push ignored when full, pop ignored when empty; flush clears everything.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   flush_i            drop every queued entry this cycle
//   push_i, push_dat_i write push_dat_i at tail
//   pop_i              retire the head entry
//   head_o             entry at head (meaningless when empty_o)
//   count_o            occupancy 0..DEPTH
//   full_o, empty_o    occupancy flags
module wb_result_fifo
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH = WB_SLOW_FIFO_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  exe_wb_scalar_instr_t       push_dat_i,
  input  logic                       pop_i,
  output exe_wb_scalar_instr_t       head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  exe_wb_scalar_instr_t mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_en;
  logic pop_en;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);

  // Guard the pointers against misuse; a flush wins over both.
  assign push_en = push_i & ~full_o & ~flush_i;
  assign pop_en  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_en) tail_d = tail_q + PTR_W'(1);
      if (pop_en)  head_d = head_q + PTR_W'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[tail_q] <= push_dat_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  a_count_in_range: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= DEPTH_CNT);

endmodule

// File: rtl/wb_scalar_arbiter.sv
// Merges ALU and long-latency scalar results onto one registered writeback port.
// Latency: 1 cycle for ALU and for slow bypass; queued slow results leave on the first ALU-idle cycle.
// Backpressure: ALU never stalls; slow channel uses slow_ready_o (FIFO not full, no flush); alu_hold_o advises issue.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   flush_i        kill queued results and this cycle's inputs
//   alu_instr_i    single-cycle result, always accepted
//   slow_instr_i   mul/div result, transferred when valid & slow_ready_o
//   slow_ready_o   slow channel can accept this cycle
//   wb_instr_o     registered writeback result
//   alu_hold_o     registered advisory: queued results are starving
//   fifo_count_o   slow FIFO occupancy
module wb_scalar_arbiter
  import drac_pkg::*;
#(
  parameter int unsigned DEPTH        = WB_SLOW_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  exe_wb_scalar_instr_t   alu_instr_i,
  input  exe_wb_scalar_instr_t   slow_instr_i,
  output logic                   slow_ready_o,
  output exe_wb_scalar_instr_t   wb_instr_o,
  output logic                   alu_hold_o,
  output logic [$clog2(DEPTH):0] fifo_count_o
);

  localparam int unsigned STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT - 1);

  exe_wb_scalar_instr_t   fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  logic                   slow_xfer;
  logic                   fifo_push;
  logic                   fifo_pop;
  wb_sel_e                sel;

  exe_wb_scalar_instr_t   wb_q, wb_d;
  logic [STARVE_W-1:0]    starve_q, starve_d;
  logic                   hold_q, hold_d;

  // No credit is given for a same-cycle pop: a full FIFO refuses even if it drains now.
  assign slow_ready_o = ~fifo_full & ~flush_i;
  assign slow_xfer    = slow_instr_i.valid & slow_ready_o;

  // Source priority: flush, ALU, queued slow, bypassed slow.
  always_comb begin
    sel = WB_SEL_NONE;
    if (flush_i) begin
      sel = WB_SEL_NONE;
    end else if (alu_instr_i.valid) begin
      sel = WB_SEL_ALU;
    end else if (!fifo_empty) begin
      sel = WB_SEL_FIFO;
    end else if (slow_xfer) begin
      sel = WB_SEL_BYPASS;
    end
  end

  // A bypassed result goes straight to the output register and is not queued.
  assign fifo_pop  = (sel == WB_SEL_FIFO);
  assign fifo_push = slow_xfer & (sel != WB_SEL_BYPASS);

  always_comb begin
    wb_d = EXE_WB_SCALAR_NOP;
    unique case (sel)
      WB_SEL_ALU:    wb_d = alu_instr_i;
      WB_SEL_FIFO:   wb_d = fifo_head;
      WB_SEL_BYPASS: wb_d = slow_instr_i;
      default:       wb_d = EXE_WB_SCALAR_NOP;
    endcase
  end

  // Counts consecutive cycles where something is queued but nothing leaves.
  // It saturates at STARVE_MAX; once there, every further no-pop cycle keeps
  // the hold request asserted for the following cycle.
  always_comb begin
    starve_d = starve_q;
    if (flush_i || fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + STARVE_W'(1);
    end
    hold_d = ~flush_i & ~fifo_pop & ~fifo_empty & (starve_q == STARVE_MAX);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_q     <= EXE_WB_SCALAR_NOP;
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      wb_q     <= wb_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
    end
  end

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_slow_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .push_i     (fifo_push),
    .push_dat_i (slow_instr_i),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign wb_instr_o   = wb_q;
  assign alu_hold_o   = hold_q;
  assign fifo_count_o = fifo_count;

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_push |-> !fifo_full);
  a_no_pop_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_pop |-> !fifo_empty);

endmodule

// File: tb/tb_wb_scalar_arbiter.sv
// Self-checking bench for wb_scalar_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the arbitration rules.
module tb_wb_scalar_arbiter;
  import drac_pkg::*;

  localparam int DEPTH  = WB_SLOW_FIFO_DEPTH;
  localparam int STARVE = WB_STARVE_LIMIT;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic                 flush_i;
  exe_wb_scalar_instr_t alu_instr_i;
  exe_wb_scalar_instr_t slow_instr_i;
  logic                 slow_ready_o;
  exe_wb_scalar_instr_t wb_instr_o;
  logic                 alu_hold_o;
  logic [CW-1:0]        fifo_count_o;

  always #5 clk_i = ~clk_i;

  wb_scalar_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .alu_instr_i  (alu_instr_i),
    .slow_instr_i (slow_instr_i),
    .slow_ready_o (slow_ready_o),
    .wb_instr_o   (wb_instr_o),
    .alu_hold_o   (alu_hold_o),
    .fifo_count_o (fifo_count_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: output register, queue of pending slow results,
  // length of the current run of starving cycles, and the hold flag.
  exe_wb_scalar_instr_t exp_wb;
  exe_wb_scalar_instr_t exp_q[$];
  int                   exp_run;
  logic                 exp_hold;

  function automatic exe_wb_scalar_instr_t mk(input logic v, input int prd, input logic [63:0] res);
    exe_wb_scalar_instr_t t;
    logic [63:0] r64;
    r64        = {$urandom, $urandom};
    t.valid    = v;
    t.pc       = r64[39:0];
    t.rd       = 5'($urandom);
    t.prd      = 6'(prd);
    t.regwr    = 1'($urandom);
    t.result   = res;
    t.gl_index = 5'($urandom);
    t.ex_valid = 1'($urandom);
    t.ex_cause = 4'($urandom);
    return t;
  endfunction

  function automatic exe_wb_scalar_instr_t mk_rand(input logic v);
    return mk(v, int'($urandom_range(0, 63)), {$urandom, $urandom});
  endfunction

  function automatic logic exp_ready();
    return (exp_q.size() < DEPTH) && !flush_i;
  endfunction

  task automatic model_reset();
    exp_wb   = '0;
    exp_q.delete();
    exp_run  = 0;
    exp_hold = 1'b0;
  endtask

  task automatic drive(input exe_wb_scalar_instr_t a, input exe_wb_scalar_instr_t s, input logic fl);
    alu_instr_i  = a;
    slow_instr_i = s;
    flush_i      = fl;
    #1;
  endtask

  // Advance the model by one cycle with the currently driven inputs, then clock the DUT.
  task automatic tick();
    int   sz;
    logic xfer;
    logic popped;
    sz     = exp_q.size();
    xfer   = slow_instr_i.valid && (sz < DEPTH) && !flush_i;
    popped = 1'b0;
    if (flush_i) begin
      exp_wb = '0;
      exp_q.delete();
    end else if (alu_instr_i.valid) begin
      exp_wb = alu_instr_i;
      if (xfer) exp_q.push_back(slow_instr_i);
    end else if (sz > 0) begin
      exp_wb = exp_q.pop_front();
      popped = 1'b1;
      if (xfer) exp_q.push_back(slow_instr_i);
    end else if (xfer) begin
      exp_wb = slow_instr_i;
    end else begin
      exp_wb = '0;
    end
    exp_hold = (sz > 0) && !popped && !flush_i && (exp_run >= STARVE - 1);
    if (flush_i || popped || sz == 0) exp_run = 0;
    else                              exp_run = exp_run + 1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive(EXE_WB_SCALAR_NOP, EXE_WB_SCALAR_NOP, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (wb_instr_o !== '0) begin errors++; $display("FAIL reset_wb: got %h expected 0", wb_instr_o); end
    checks++; if (fifo_count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count_o); end
    checks++; if (alu_hold_o !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b expected 0", alu_hold_o); end
    rst_i = 1'b0;
    #1;
    checks++; if (slow_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", slow_ready_o); end
    // Build up state, then reset asynchronously between edges.
    for (int i = 0; i < 3; i++) begin
      drive(mk(1'b1, 1 + i, 64'(i)), mk(1'b1, 30 + i, 64'(100 + i)), 1'b0);
      tick();
    end
    checks++; if (fifo_count_o !== CW'(3)) begin errors++; $display("FAIL midrst_pre_count: got %0d expected 3", fifo_count_o); end
    checks++; if (wb_instr_o.valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", wb_instr_o.valid); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (wb_instr_o !== '0) begin errors++; $display("FAIL midrst_wb: got %h expected 0", wb_instr_o); end
    checks++; if (fifo_count_o !== '0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", fifo_count_o); end
    checks++; if (alu_hold_o !== 1'b0) begin errors++; $display("FAIL midrst_hold: got %b expected 0", alu_hold_o); end
    alu_instr_i  = EXE_WB_SCALAR_NOP;
    slow_instr_i = EXE_WB_SCALAR_NOP;
    flush_i      = 1'b0;
    model_reset();
    #1;
    rst_i = 1'b0;
    #1;
    checks++; if (slow_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", slow_ready_o); end
  endtask

  task automatic test_bypass();
    exe_wb_scalar_instr_t s;
    s = mk(1'b1, 12, 64'h2A);
    drive(EXE_WB_SCALAR_NOP, s, 1'b0);
    checks++; if (slow_ready_o !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b expected 1", slow_ready_o); end
    tick();
    checks++; if (wb_instr_o.valid !== 1'b1 || wb_instr_o.prd !== 6'd12 || wb_instr_o.result !== 64'h2A)
      begin errors++; $display("FAIL bypass_fields: got v=%b prd=%0d res=%h expected v=1 prd=12 res=2a", wb_instr_o.valid, wb_instr_o.prd, wb_instr_o.result); end
    checks++; if (wb_instr_o !== s) begin errors++; $display("FAIL bypass_copy: got %h expected %h", wb_instr_o, s); end
    checks++; if (fifo_count_o !== '0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", fifo_count_o); end
  endtask

  task automatic test_conflict();
    drive(mk(1'b1, 5, 64'h55), mk(1'b1, 9, 64'h99), 1'b0);
    tick();
    checks++; if (wb_instr_o.prd !== 6'd5 || wb_instr_o !== exp_wb) begin errors++; $display("FAIL conflict_alu: got prd=%0d expected prd=5", wb_instr_o.prd); end
    checks++; if (fifo_count_o !== CW'(1)) begin errors++; $display("FAIL conflict_count1: got %0d expected 1", fifo_count_o); end
    drive(EXE_WB_SCALAR_NOP, EXE_WB_SCALAR_NOP, 1'b0);
    tick();
    checks++; if (wb_instr_o.prd !== 6'd9 || wb_instr_o.result !== 64'h99 || wb_instr_o !== exp_wb)
      begin errors++; $display("FAIL conflict_slow: got prd=%0d res=%h expected prd=9 res=99", wb_instr_o.prd, wb_instr_o.result); end
    checks++; if (fifo_count_o !== '0) begin errors++; $display("FAIL conflict_count0: got %0d expected 0", fifo_count_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      drive(mk(1'b1, 20 + i, 64'(i)), mk(1'b1, 40 + i, 64'(200 + i)), 1'b0);
      checks++; if (slow_ready_o !== (i < 4)) begin errors++; $display("FAIL full_ready%0d: got %b expected %b", i, slow_ready_o, (i < 4)); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(EXE_WB_SCALAR_NOP, EXE_WB_SCALAR_NOP, 1'b0);
      checks++; if (slow_ready_o !== (i > 0)) begin errors++; $display("FAIL drain_ready%0d: got %b expected %b", i, slow_ready_o, (i > 0)); end
      tick();
      checks++; if (wb_instr_o.prd !== 6'(40 + i) || wb_instr_o !== exp_wb)
        begin errors++; $display("FAIL drain_order%0d: got prd=%0d expected prd=%0d", i, wb_instr_o.prd, 40 + i); end
      checks++; if (fifo_count_o !== CW'(3 - i)) begin errors++; $display("FAIL drain_count%0d: got %0d expected %0d", i, fifo_count_o, 3 - i); end
    end
  endtask

  task automatic test_starve();
    exe_wb_scalar_instr_t a;
    drive(mk(1'b1, 1, 64'h1), mk(1'b1, 50, 64'h50), 1'b0);
    tick();
    // Cycles 1..8 are no-pop cycles with one entry queued; hold shows up in cycle 9.
    for (int c = 1; c <= 8; c++) begin
      drive(mk(1'b1, c, 64'(c)), EXE_WB_SCALAR_NOP, 1'b0);
      tick();
      checks++; if (alu_hold_o !== (c == 8) || alu_hold_o !== exp_hold)
        begin errors++; $display("FAIL starve_hold_c%0d: got %b expected %b", c + 1, alu_hold_o, (c == 8)); end
    end
    a = mk(1'b1, 33, 64'h33);
    drive(a, EXE_WB_SCALAR_NOP, 1'b0);
    tick();
    checks++; if (wb_instr_o !== a) begin errors++; $display("FAIL starve_alu_wins: got %h expected %h", wb_instr_o, a); end
    checks++; if (alu_hold_o !== 1'b1) begin errors++; $display("FAIL starve_hold_kept: got %b expected 1", alu_hold_o); end
    drive(EXE_WB_SCALAR_NOP, EXE_WB_SCALAR_NOP, 1'b0);
    tick();
    checks++; if (wb_instr_o.prd !== 6'd50 || wb_instr_o !== exp_wb) begin errors++; $display("FAIL starve_pop: got prd=%0d expected prd=50", wb_instr_o.prd); end
    checks++; if (alu_hold_o !== 1'b0) begin errors++; $display("FAIL starve_release: got %b expected 0", alu_hold_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(mk(1'b1, 10 + i, 64'(i)), mk(1'b1, 20 + i, 64'(i)), 1'b0);
      tick();
    end
    checks++; if (fifo_count_o !== CW'(3)) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", fifo_count_o); end
    drive(mk(1'b1, 60, 64'h60), mk(1'b1, 61, 64'h61), 1'b1);
    checks++; if (slow_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", slow_ready_o); end
    checks++; if (wb_instr_o.valid !== 1'b1 || wb_instr_o.prd !== 6'd12)
      begin errors++; $display("FAIL flush_inflight: got v=%b prd=%0d expected v=1 prd=12", wb_instr_o.valid, wb_instr_o.prd); end
    tick();
    checks++; if (wb_instr_o.valid !== 1'b0) begin errors++; $display("FAIL flush_wb: got %b expected 0", wb_instr_o.valid); end
    checks++; if (fifo_count_o !== '0) begin errors++; $display("FAIL flush_count: got %0d expected 0", fifo_count_o); end
    drive(EXE_WB_SCALAR_NOP, EXE_WB_SCALAR_NOP, 1'b0);
    checks++; if (slow_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b expected 1", slow_ready_o); end
    tick();
    checks++; if (wb_instr_o.valid !== 1'b0) begin errors++; $display("FAIL flush_no_leak: got %b expected 0", wb_instr_o.valid); end
  endtask

  task automatic test_random();
    logic fl;
    for (int n = 0; n < 600; n++) begin
      fl = ($urandom_range(0, 99) < 4);
      drive(mk_rand($urandom_range(0, 99) < 55), mk_rand($urandom_range(0, 99) < 65), fl);
      checks++; if (slow_ready_o !== exp_ready()) begin errors++; $display("FAIL rand_ready@%0d: got %b expected %b", n, slow_ready_o, exp_ready()); end
      tick();
      checks++;
      if (exp_wb.valid ? (wb_instr_o !== exp_wb) : (wb_instr_o.valid !== 1'b0))
        begin errors++; $display("FAIL rand_wb@%0d: got %h expected %h", n, wb_instr_o, exp_wb); end
      checks++; if (fifo_count_o !== CW'(exp_q.size())) begin errors++; $display("FAIL rand_count@%0d: got %0d expected %0d", n, fifo_count_o, exp_q.size()); end
      checks++; if (alu_hold_o !== exp_hold) begin errors++; $display("FAIL rand_hold@%0d: got %b expected %b", n, alu_hold_o, exp_hold); end
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    alu_instr_i  = EXE_WB_SCALAR_NOP;
    slow_instr_i = EXE_WB_SCALAR_NOP;
    model_reset();
    test_reset();
    test_bypass();
    drain();
    test_conflict();
    drain();
    test_full();
    drain();
    test_starve();
    drain();
    test_flush();
    drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
